// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default widths, bubble word, jump opcode and FSM state encoding.
package fetch_pkg;
    localparam int PC_WIDTH_DEF    = 8;
    localparam int INSTR_WIDTH_DEF = 10;

    localparam logic [INSTR_WIDTH_DEF-1:0] BUBBLE_INSTR = '1;
    localparam logic [3:0]                 OPC_JMP      = 4'b1001;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_START = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_HALT  = 2'd2;
endpackage

// File: rtl/fetch_if.sv
// Fetch bus: decoder controls, ROM port and instruction stream. master = fetch unit, slave = decoder/ROM side.
interface fetch_if #(
    parameter int PC_WIDTH    = fetch_pkg::PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH_DEF
);
    logic                   stall;
    logic                   load;
    logic [PC_WIDTH-1:0]    set_value;
    logic [PC_WIDTH-1:0]    rom_addr;
    logic [INSTR_WIDTH-1:0] rom_data;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;
    logic                   halted;

    modport master (
        input  stall, load, set_value, rom_data,
        output rom_addr, instruction, instr_pc, instr_valid, halted
    );

    modport slave (
        output stall, load, set_value, rom_data,
        input  rom_addr, instruction, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/program_counter.sv
// Program counter register: synchronous reset to RESET_VECTOR, load has priority over increment, otherwise hold.
module program_counter
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                ld,
    input  logic [PC_WIDTH-1:0] ld_value,
    output logic [PC_WIDTH-1:0] pc
);

    // Increment wraps naturally at 2^PC_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (ld) begin
            pc <= ld_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FSM plus instruction register in front of a combinational program ROM.
// Optional macro FETCH_HALT_EN: a jump to the current instruction's own address halts fetch until reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_START | after reset, nothing captured yet; next unstalled edge fetches
// ST_RUN   | fetching sequentially, accepting jumps from the decoder
// ST_HALT  | fetch stopped for good (jump-to-self with FETCH_HALT_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    fetch_state_t           state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    instr_pc_q;
    logic                   valid_q;

    logic self_halt;
    logic take_jump;
    logic do_jump;
    logic enter_halt;
    logic do_fetch;

`ifdef FETCH_HALT_EN
    assign self_halt = (bus.set_value == instr_pc_q);
`else
    assign self_halt = 1'b0;
`endif

    // A load is only honoured against a real instruction; during a bubble it falls through to a fetch.
    assign take_jump  = (state == ST_RUN) && !bus.stall && bus.load && valid_q;
    assign do_jump    = take_jump && !self_halt;
    assign enter_halt = take_jump && self_halt;
    assign do_fetch   = !bus.stall && ((state == ST_START) || ((state == ST_RUN) && !take_jump));

    program_counter #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (do_fetch),
        .ld       (do_jump),
        .ld_value (bus.set_value),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_START;
            instr_q    <= '1;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else if (enter_halt) begin
            state   <= ST_HALT;
            instr_q <= '1;
            valid_q <= 1'b0;
        end else if (do_jump) begin
            instr_q <= '1;
            valid_q <= 1'b0;
        end else if (do_fetch) begin
            state      <= ST_RUN;
            instr_q    <= bus.rom_data;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;

`ifdef FETCH_HALT_EN
    assign bus.halted = (state == ST_HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8: program-counter and ROM address width.
REQ-002 Parameter INSTR_WIDTH, default 10: instruction width (4-bit opcode in [9:6]).
REQ-003 Parameter RESET_VECTOR, default 0: first fetch address after reset.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1: reset, synchronous, active-low.
REQ-006 Port stall  input  1: hold all fetch state this cycle.
REQ-007 Port load  input  1: jump request from the decoder.
REQ-008 Port set_value  input  PC_WIDTH: jump target.
REQ-009 Port rom_addr  output  PC_WIDTH: program ROM address, driven directly from the pc register.
REQ-010 Port rom_data  input  INSTR_WIDTH: combinational ROM read data for rom_addr.
REQ-011 Port instruction  output  INSTR_WIDTH: registered instruction to the decoder.
REQ-012 Port instr_pc  output  PC_WIDTH: address the current instruction was fetched from.
REQ-013 Port instr_valid  output  1: instruction holds a real fetched word.
REQ-014 Port halted  output  1: fetch permanently stopped until reset.

Function
REQ-015 FSM states SHALL be START, RUN, HALT.
REQ-016 In START: no capture, instr_valid=0; the next unstalled edge SHALL move to RUN and perform a normal fetch.
REQ-017 Normal fetch (RUN, stall=0, load=0): instruction<=rom_data, instr_pc<=pc, pc<=pc+1, instr_valid<=1.
REQ-018 Fetch latency: a word at address A SHALL appear on instruction exactly one edge after rom_addr==A.
REQ-019 pc increment SHALL wrap modulo 2^PC_WIDTH (255 -> 0 at default).
REQ-020 Jump (RUN, stall=0, load=1, instr_valid=1): pc<=set_value, instruction<=BUBBLE_INSTR (all ones), instr_valid<=0.
REQ-021 load while instr_valid=0 SHALL be ignored.
REQ-022 The bubble cycle after a jump SHALL insert exactly one invalid slot; the target word follows on the next edge.
REQ-023 stall=1 SHALL freeze pc, instruction, instr_pc, instr_valid and state; stall SHALL take priority over load.
REQ-024 In HALT: pc frozen, instruction=BUBBLE_INSTR, instr_valid=0, halted=1; stall and load ignored.

Reset
REQ-025 rst_n=0 at an edge, in any state including mid-jump or stall: pc=RESET_VECTOR, instruction=BUBBLE_INSTR, instr_pc=0, instr_valid=0, halted=0, state=START.
REQ-026 Reset SHALL take priority over stall, load and HALT.

Configuration
REQ-027 Macro FETCH_HALT_EN: when defined, a jump (REQ-020 conditions) with set_value==instr_pc SHALL enter HALT instead of jumping.
REQ-028 Without FETCH_HALT_EN: jump-to-self SHALL execute as an ordinary jump, HALT is unreachable, halted SHALL be constant 0.

Structure
REQ-029 Package fetch_pkg SHALL hold PC_WIDTH and INSTR_WIDTH defaults, BUBBLE_INSTR, OPC_JMP (4'b1001) and the FSM state typedef.
REQ-030 Sub-module program_counter SHALL hold the pc register with increment, load and hold controls; fetch_unit owns the FSM and instruction register.

Verification
REQ-031 Reset release, ROM[0..3]=0x005,0x04D,0x0AB,0x0EA, no stall -> instr_valid=0 for the first edge, then instruction 0x005,0x04D,0x0AB on consecutive edges with instr_pc 0,1,2.
REQ-032 At instr_pc=2 drive load=1, set_value=0x40 -> next edge instruction=0x3FF, instr_valid=0; following edge instruction=ROM[0x40], instr_pc=0x40.
REQ-033 stall=1 for 3 cycles with load=1 -> outputs unchanged throughout, no jump; after release fetch resumes from held pc.
REQ-034 pc=0xFF, no stall -> instr_pc=0xFF, then rom_addr=0x00 and next instr_pc=0x00.
REQ-035 FETCH_HALT_EN defined, ROM[5]=0x245 (JMP 5), decoder load=1 set_value=5 -> halted=1, instr_valid=0 held 10 cycles; rst_n=0 -> START, halted=0. Without macro -> repeated 0x245 fetches at pc 5 with a bubble between each.
REQ-036 rst_n=0 on the edge right after load=1 -> pc=RESET_VECTOR, jump discarded, instruction=0x3FF.
